// File: rtl/patch_streamer.sv
`default_nettype none
// ============================================================================
// Module   : patch_streamer
// Brief    : Raster-in, patch-ordered-out streamer using ping-pong strip banks.
// Revision : 1.0 - initial release
// ============================================================================
module patch_streamer #(
  parameter  int CHANNEL_SIZE = 8,
  parameter  int NUM_CHANNELS = 3,
  parameter  int PIXEL_WIDTH  = CHANNEL_SIZE * NUM_CHANNELS,
  parameter  int PATCH        = 16,
  parameter  int IMG_W        = 64,
  parameter  int IMG_H        = 64,
  localparam int PX           = IMG_W / PATCH,
  localparam int PY           = IMG_H / PATCH,
  localparam int NUM_PATCHES  = PX * PY,
  localparam int STRIP        = PATCH * IMG_W,
  localparam int PIDX_W       = (NUM_PATCHES > 1) ? $clog2(NUM_PATCHES) : 1,
  localparam int POS_W        = $clog2(PATCH * PATCH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PIXEL_WIDTH-1:0] in_pixel,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PIXEL_WIDTH-1:0] out_pixel,
  output logic [PIDX_W-1:0]      out_patch_idx,
  output logic [POS_W-1:0]       out_pos_idx,
  output logic                   out_patch_last,
  output logic                   out_frame_last,
  output logic                   frame_done,
  output logic                   busy
);

  typedef enum logic [1:0] {
    ST_EMPTY    = 2'd0,
    ST_FILLING  = 2'd1,
    ST_FULL     = 2'd2,
    ST_DRAINING = 2'd3
  } bank_st_t;

  localparam int c_OFF_W  = $clog2(STRIP);
  localparam int c_ADDR_W = $clog2(2 * STRIP);
  localparam int c_PX_W   = (PX > 1) ? $clog2(PX) : 1;
  localparam int c_PY_W   = (PY > 1) ? $clog2(PY) : 1;
  localparam int c_RC_W   = $clog2(PATCH);

  bank_st_t               r_bank_st    [2];
  bank_st_t               w_bank_nxt   [2];
  logic [c_PY_W-1:0]      r_bank_strip [2];
  logic [PIXEL_WIDTH-1:0] r_mem        [2*STRIP];

  logic                   r_wr_bank;
  logic                   r_rd_bank;
  logic [c_OFF_W-1:0]     r_wr_cnt;
  logic [c_PY_W-1:0]      r_strip_wr;
  logic [c_PX_W-1:0]      r_px;
  logic [c_RC_W-1:0]      r_r;
  logic [c_RC_W-1:0]      r_c;

  logic                   r_out_valid;
  logic [PIXEL_WIDTH-1:0] r_out_pixel;
  logic [PIDX_W-1:0]      r_out_patch;
  logic [POS_W-1:0]       r_out_pos;
  logic                   r_out_plast;
  logic                   r_out_flast;
  logic                   r_frame_done;

  logic                   w_rd_avail;
  logic                   w_load;
  logic                   w_rd_last;
  logic                   w_release;
  logic                   w_wr_open;
  logic                   w_in_fire;
  logic                   w_wr_last;
  logic [c_OFF_W-1:0]     w_rd_off;
  logic [c_ADDR_W-1:0]    w_rd_idx;
  logic [c_ADDR_W-1:0]    w_wr_idx;
  logic [PIDX_W-1:0]      w_patch_idx;
  logic [POS_W-1:0]       w_pos_idx;
  logic                   w_plast;
  logic                   w_flast;

  assign w_rd_avail = (r_bank_st[r_rd_bank] == ST_FULL) || (r_bank_st[r_rd_bank] == ST_DRAINING);
  assign w_load     = w_rd_avail && (!r_out_valid || out_ready);
  assign w_rd_last  = (r_px == c_PX_W'(PX - 1)) && (r_r == c_RC_W'(PATCH - 1)) &&
                      (r_c == c_RC_W'(PATCH - 1));
  assign w_release  = w_load && w_rd_last;

  // A bank released by the reader this cycle is writable in the same cycle.
  assign w_wr_open  = (r_bank_st[r_wr_bank] == ST_EMPTY) || (r_bank_st[r_wr_bank] == ST_FILLING) ||
                      (w_release && (r_rd_bank == r_wr_bank));
  assign in_ready   = reset && w_wr_open;
  assign w_in_fire  = in_valid && in_ready;
  assign w_wr_last  = (r_wr_cnt == c_OFF_W'(STRIP - 1));

  assign w_rd_off    = c_OFF_W'(int'(r_r) * IMG_W + int'(r_px) * PATCH + int'(r_c));
  assign w_rd_idx    = c_ADDR_W'(int'(r_rd_bank) * STRIP + int'(w_rd_off));
  assign w_wr_idx    = c_ADDR_W'(int'(r_wr_bank) * STRIP + int'(r_wr_cnt));
  assign w_patch_idx = PIDX_W'(int'(r_bank_strip[r_rd_bank]) * PX + int'(r_px));
  assign w_pos_idx   = POS_W'(int'(r_r) * PATCH + int'(r_c));
  assign w_plast     = (r_r == c_RC_W'(PATCH - 1)) && (r_c == c_RC_W'(PATCH - 1));
  assign w_flast     = w_plast && (w_patch_idx == PIDX_W'(NUM_PATCHES - 1));

  // Writer update is applied last so it wins when it refills a just-released bank.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      w_bank_nxt[b] = r_bank_st[b];
      if (w_load && (r_rd_bank == 1'(b)))
        w_bank_nxt[b] = w_rd_last ? ST_EMPTY : ST_DRAINING;
      if (w_in_fire && (r_wr_bank == 1'(b)))
        w_bank_nxt[b] = w_wr_last ? ST_FULL : ST_FILLING;
    end
  end

  always_ff @(posedge clk) begin
    if (w_in_fire)
      r_mem[w_wr_idx] <= in_pixel;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int b = 0; b < 2; b++) begin
        r_bank_st[b]    <= ST_EMPTY;
        r_bank_strip[b] <= '0;
      end
      r_wr_bank    <= 1'b0;
      r_rd_bank    <= 1'b0;
      r_wr_cnt     <= '0;
      r_strip_wr   <= '0;
      r_px         <= '0;
      r_r          <= '0;
      r_c          <= '0;
      r_out_valid  <= 1'b0;
      r_out_pixel  <= '0;
      r_out_patch  <= '0;
      r_out_pos    <= '0;
      r_out_plast  <= 1'b0;
      r_out_flast  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      for (int b = 0; b < 2; b++)
        r_bank_st[b] <= w_bank_nxt[b];
      r_frame_done <= r_out_valid && out_ready && r_out_flast;

      if (w_in_fire) begin
        if (w_wr_last) begin
          r_wr_cnt                <= '0;
          r_wr_bank               <= ~r_wr_bank;
          r_bank_strip[r_wr_bank] <= r_strip_wr;
          r_strip_wr              <= (r_strip_wr == c_PY_W'(PY - 1)) ? '0 : r_strip_wr + 1'b1;
        end else begin
          r_wr_cnt <= r_wr_cnt + 1'b1;
        end
      end

      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_pixel <= r_mem[w_rd_idx];
        r_out_patch <= w_patch_idx;
        r_out_pos   <= w_pos_idx;
        r_out_plast <= w_plast;
        r_out_flast <= w_flast;
        if (r_c == c_RC_W'(PATCH - 1)) begin
          r_c <= '0;
          if (r_r == c_RC_W'(PATCH - 1)) begin
            r_r <= '0;
            if (r_px == c_PX_W'(PX - 1)) begin
              r_px      <= '0;
              r_rd_bank <= ~r_rd_bank;
            end else begin
              r_px <= r_px + 1'b1;
            end
          end else begin
            r_r <= r_r + 1'b1;
          end
        end else begin
          r_c <= r_c + 1'b1;
        end
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid      = r_out_valid;
  assign out_pixel      = r_out_pixel;
  assign out_patch_idx  = r_out_patch;
  assign out_pos_idx    = r_out_pos;
  assign out_patch_last = r_out_plast;
  assign out_frame_last = r_out_flast;
  assign frame_done     = r_frame_done;
  assign busy           = (r_bank_st[0] != ST_EMPTY) || (r_bank_st[1] != ST_EMPTY) || r_out_valid;

endmodule
`default_nettype wire
